// File: rtl/projectile_engine_if.sv
// Shell engine bus between a tank controller (master) and its projectile engine (slave).
interface projectile_engine_if;
  logic       shoot;
  logic [1:0] Direction;
  logic [9:0] TankX, TankY, y_component;
  logic [9:0] TargetX, TargetY, TargetS;
  logic [9:0] BulletX, BulletY, BulletS;
  logic       bullet_on, burst_on, hit, busy;

  modport master (
    output shoot, Direction, TankX, TankY, y_component, TargetX, TargetY, TargetS,
    input  BulletX, BulletY, BulletS, bullet_on, burst_on, hit, busy
  );
  modport slave (
    input  shoot, Direction, TankX, TankY, y_component, TargetX, TargetY, TargetS,
    output BulletX, BulletY, BulletS, bullet_on, burst_on, hit, busy
  );
endinterface

// File: rtl/projectile_engine.sv
// One-shell projectile engine: launch latch, per-frame step, hull/screen tests, burst timer.
// Gravity on vy is built only when PROJ_GRAVITY_EN is defined.
module projectile_engine #(
  parameter int X_SPEED      = 4,
  parameter int VY_MAX       = 8,
  parameter int GRAV_DIV     = 4,
  parameter int BURST_FRAMES = 16,
  parameter int SHELL_S      = 2
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  projectile_engine_if.slave bus
);
  localparam int BCW = $clog2(BURST_FRAMES + 1);
  localparam logic signed [9:0] VX   = 10'(X_SPEED);
  localparam logic signed [9:0] VMAX = 10'(VY_MAX);

  if (X_SPEED < 1 || X_SPEED > 15 || VY_MAX < 1 || GRAV_DIV < 1 || BURST_FRAMES < 1) begin : g_param_check
    $error("projectile_engine: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, FLIGHT, BURST} state_t;

  state_t                state, state_nx;
  logic [9:0]            bx, by, bx_nx, by_nx;
  logic signed [9:0]     vx, vy, vx_nx, vy_nx, vy_launch;
  logic [BCW-1:0]        bcnt, bcnt_nx;
  logic                  face, hit_r, hit_nx, bullet_r, burst_r, busy_r;
  logic [10:0]           dx, dy, reach;
  logic signed [11:0]    nx, ny;
  logic                  contact, off_screen;
`ifdef PROJ_GRAVITY_EN
  localparam int GCW = $clog2(GRAV_DIV + 1);
  logic [GCW-1:0]        gcnt, gcnt_nx;
`endif

  // Distances use 11 bits so the subtraction never wraps.
  always_comb begin
    dx = (bx >= bus.TargetX) ? {1'b0, bx} - {1'b0, bus.TargetX} : {1'b0, bus.TargetX} - {1'b0, bx};
    dy = (by >= bus.TargetY) ? {1'b0, by} - {1'b0, bus.TargetY} : {1'b0, bus.TargetY} - {1'b0, by};
    reach = 11'(SHELL_S) + {1'b0, bus.TargetS};
    contact = (dx <= reach) && (dy <= reach);
    nx = $signed({2'b00, bx}) + $signed({{2{vx[9]}}, vx});
    ny = $signed({2'b00, by}) + $signed({{2{vy[9]}}, vy});
    off_screen = nx[11] || (nx > 12'sd639) || ny[11] || (ny > 12'sd479);
    if ($signed(bus.y_component) > VMAX)       vy_launch = VMAX;
    else if ($signed(bus.y_component) < -VMAX) vy_launch = -VMAX;
    else                                       vy_launch = $signed(bus.y_component);
  end

  always_comb begin
    state_nx = state;
    bx_nx    = bx;
    by_nx    = by;
    vx_nx    = vx;
    vy_nx    = vy;
    bcnt_nx  = bcnt;
    hit_nx   = 1'b0;
`ifdef PROJ_GRAVITY_EN
    gcnt_nx  = gcnt;
`endif
    case (state)
      IDLE: if (bus.shoot) begin
        state_nx = FLIGHT;
        bx_nx    = bus.TankX;
        by_nx    = bus.TankY;
        vx_nx    = face ? VX : -VX;
        vy_nx    = vy_launch;
`ifdef PROJ_GRAVITY_EN
        gcnt_nx  = '0;
`endif
      end
      FLIGHT: begin
        // Contact on the current position outranks leaving the screen.
        if (contact) begin
          hit_nx   = 1'b1;
          state_nx = BURST;
          bcnt_nx  = '0;
        end else if (off_screen) begin
          state_nx = IDLE;
        end else begin
          bx_nx = nx[9:0];
          by_nx = ny[9:0];
`ifdef PROJ_GRAVITY_EN
          if (gcnt == GCW'(GRAV_DIV - 1)) begin
            gcnt_nx = '0;
            if (vy < VMAX) vy_nx = vy + 10'sd1;
          end else begin
            gcnt_nx = gcnt + 1'b1;
          end
`endif
        end
      end
      BURST: begin
        if (bcnt == BCW'(BURST_FRAMES - 1)) state_nx = IDLE;
        else                                bcnt_nx  = bcnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      bx       <= '0;
      by       <= '0;
      vx       <= '0;
      vy       <= '0;
      bcnt     <= '0;
      face     <= 1'b1;
      hit_r    <= 1'b0;
      bullet_r <= 1'b0;
      burst_r  <= 1'b0;
      busy_r   <= 1'b0;
`ifdef PROJ_GRAVITY_EN
      gcnt     <= '0;
`endif
    end else begin
      state    <= state_nx;
      bx       <= bx_nx;
      by       <= by_nx;
      vx       <= vx_nx;
      vy       <= vy_nx;
      bcnt     <= bcnt_nx;
      hit_r    <= hit_nx;
      bullet_r <= (state_nx == FLIGHT);
      burst_r  <= (state_nx == BURST);
      busy_r   <= (state_nx != IDLE);
      if (!bus.Direction[1]) face <= bus.Direction[0];
`ifdef PROJ_GRAVITY_EN
      gcnt     <= gcnt_nx;
`endif
    end
  end

  assign bus.BulletX   = bx;
  assign bus.BulletY   = by;
  assign bus.BulletS   = 10'(SHELL_S);
  assign bus.bullet_on = bullet_r;
  assign bus.burst_on  = burst_r;
  assign bus.hit       = hit_r;
  assign bus.busy      = busy_r;
endmodule
